// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: valid/ready bus around the immediate extension stage.
// Ports: in_* carry the raw field from the producer; out_* carry the result to the consumer.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 16,
  parameter int LEN_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  data_in;
  logic [LEN_W-1:0] len;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] data_out;
  logic             err;

  modport master (
    output in_valid, data_in, len, mode, out_ready,
    input  in_ready, out_valid, data_out, err
  );

  modport slave (
    input  in_valid, data_in, len, mode, out_ready,
    output in_ready, out_valid, data_out, err
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: zero/sign/sign-shift extension of a len-bit field, 1 output slot.
// Ports: clk, rst_n (sync, low), bus (slave side of the handshake), item_cnt (results taken).
module imm_extend_pipe #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 16,
  parameter int LEN_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_extend_pipe_if.slave bus,
  output logic [CNT_W-1:0] item_cnt
);
  localparam logic [LEN_W-1:0] LP_INW = LEN_W'(IN_W);

  logic             r_valid;
  logic [OUT_W-1:0] r_data;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_ready;
  logic             w_acc;
  logic             w_xfer;
  logic             w_len_bad;
  logic [LEN_W-1:0] w_len_eff;
  logic [OUT_W-1:0] w_mask;
  logic [OUT_W-1:0] w_top;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic             w_sbit;
  logic [OUT_W-1:0] w_res;
  logic             w_err;

  assign w_in_ready = !r_valid || bus.out_ready;
  assign w_acc      = bus.in_valid && w_in_ready;
  assign w_xfer     = r_valid && bus.out_ready;

  assign w_len_bad = (bus.len == '0) || (bus.len > LP_INW);
  assign w_len_eff = w_len_bad ? LP_INW : bus.len;

  // w_top is one-hot at bit L-1: it selects the sign bit.
  assign w_mask = ~({OUT_W{1'b1}} << w_len_eff);
  assign w_top  = w_mask ^ (w_mask >> 1);
  assign w_zext = {{(OUT_W-IN_W){1'b0}}, bus.data_in} & w_mask;
  assign w_sbit = |(w_zext & w_top);
  assign w_sext = w_sbit ? (w_zext | ~w_mask) : w_zext;

  always_comb begin
    w_res = w_zext;
    unique case (1'b1)
      (bus.mode == 2'b01): w_res = w_sext;
      (bus.mode == 2'b10): w_res = {w_sext[OUT_W-2:0], 1'b0};
      default:             w_res = w_zext;
    endcase
  end

  assign w_err = w_len_bad || (bus.mode == 2'b11);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_acc) begin
        r_valid <= 1'b1;
        r_data  <= w_res;
        r_err   <= w_err;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_xfer) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.data_out  = r_data;
  assign bus.err       = r_err;
  assign item_cnt      = r_cnt;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed vectors plus handshake, reset and wrap sequences.
// Uses a 4-bit item counter so the wrap sequence stays short.
module tb_imm_extend_pipe;
  logic       clk;
  logic       rst_n;
  logic [3:0] item_cnt;

  int total;
  int bad;
  logic [3:0] exp_cnt;

  imm_extend_pipe_if #(.IN_W(10), .OUT_W(16), .LEN_W(4)) bus ();

  imm_extend_pipe #(
    .IN_W(10), .OUT_W(16), .LEN_W(4), .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .item_cnt(item_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  din;
    logic [3:0]  len;
    logic [1:0]  mode;
    logic [15:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t vt[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] d, input logic [3:0] l,
                       input logic [1:0] m);
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.len      = l;
    bus.mode     = m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    bus.in_valid = 1'b0;
    bus.data_in = '0;
    bus.len = '0;
    bus.mode = '0;
    bus.out_ready = 1'b1;

    vt[0] = '{10'h100, 4'd9,  2'b01, 16'hFF00, 1'b0};
    vt[1] = '{10'h100, 4'd10, 2'b01, 16'h0100, 1'b0};
    vt[2] = '{10'h100, 4'd9,  2'b00, 16'h0100, 1'b0};
    vt[3] = '{10'h100, 4'd9,  2'b10, 16'hFE00, 1'b0};
    vt[4] = '{10'h3FF, 4'd4,  2'b01, 16'hFFFF, 1'b0};
    vt[5] = '{10'h3F7, 4'd4,  2'b01, 16'h0007, 1'b0};
    vt[6] = '{10'h200, 4'd0,  2'b01, 16'hFE00, 1'b1};
    vt[7] = '{10'h0FF, 4'd12, 2'b00, 16'h00FF, 1'b1};
    vt[8] = '{10'h3FF, 4'd10, 2'b11, 16'h03FF, 1'b1};

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    exp_cnt = '0;
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.data_out, 0);
    check("rst_err", bus.err, 0);
    check("rst_cnt", item_cnt, 0);
    check("rst_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].din, vt[i].len, vt[i].mode);
      step();
      bus.in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), bus.out_valid, 1);
      check($sformatf("vec%0d_data", i), bus.data_out, vt[i].exp);
      check($sformatf("vec%0d_err", i), bus.err, vt[i].exp_err);
      step();
      exp_cnt++;
      check($sformatf("vec%0d_clr", i), bus.out_valid, 0);
      check($sformatf("vec%0d_hold", i), bus.data_out, vt[i].exp);
      check($sformatf("vec%0d_cnt", i), item_cnt, exp_cnt);
    end

    drive(10'h005, 4'd10, 2'b01);
    step();
    check("bp_first", bus.data_out, 16'h0005);
    bus.out_ready = 1'b0;
    drive(10'h3FF, 4'd10, 2'b01);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp_in_ready%0d", k), bus.in_ready, 0);
      check($sformatf("bp_valid%0d", k), bus.out_valid, 1);
      check($sformatf("bp_data%0d", k), bus.data_out, 16'h0005);
      check($sformatf("bp_cnt%0d", k), item_cnt, exp_cnt);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    exp_cnt++;
    check("bp_swap_valid", bus.out_valid, 1);
    check("bp_swap_data", bus.data_out, 16'hFFFF);
    check("bp_swap_cnt", item_cnt, exp_cnt);
    step();
    exp_cnt++;
    check("bp_drain_cnt", item_cnt, exp_cnt);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(10'h3F0 + 10'(i), 4'd10, 2'b01);
      step();
      check($sformatf("st%0d_valid", i), bus.out_valid, 1);
      check($sformatf("st%0d_data", i), bus.data_out, 16'hFFF0 + 16'(i));
      check($sformatf("st%0d_cnt", i), item_cnt, i);
    end
    bus.in_valid = 1'b0;
    step();
    check("st_end_valid", bus.out_valid, 0);
    check("st_end_cnt", item_cnt, 8);

    bus.out_ready = 1'b0;
    drive(10'h200, 4'd0, 2'b01);
    step();
    bus.in_valid = 1'b0;
    check("mr_pre_valid", bus.out_valid, 1);
    check("mr_pre_err", bus.err, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mr_valid", bus.out_valid, 0);
    check("mr_data", bus.data_out, 0);
    check("mr_err", bus.err, 0);
    check("mr_cnt", item_cnt, 0);
    check("mr_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    drive(10'h3F7, 4'd4, 2'b01);
    step();
    bus.in_valid = 1'b0;
    check("mr_next_valid", bus.out_valid, 1);
    check("mr_next_data", bus.data_out, 16'h0007);
    check("mr_next_err", bus.err, 0);
    step();

    do_reset();
    for (int k = 1; k <= 17; k++) begin
      drive(10'(k), 4'd10, 2'b00);
      step();
      bus.in_valid = 1'b0;
      step();
      check($sformatf("wrap%0d", k), item_cnt, k % 16);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, handshaked extension stage: takes an IN_W-bit immediate field, treats the low `len` bits as the field, and produces an OUT_W-bit word.
- Modes: zero-extend, sign-extend, or sign-extend then shift left by one (halfword branch offsets).
- Sits between the instruction field splitter and the ALU/branch operand muxes.
- One registered output slot with valid/ready back-pressure, plus a processed-item counter and an error flag.

Parameters:
- IN_W, 10, width of data_in.
- OUT_W, 16, width of data_out; must be > IN_W.
- LEN_W, 4, width of len input; must satisfy 2^LEN_W > IN_W.
- CNT_W, 16, width of the processed-item counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input item present.
- in_ready  out  1  stage can accept an item this cycle.
- data_in  in  IN_W  raw immediate.
- len  in  LEN_W  field length in bits, legal 1..IN_W.
- mode  in  2  00 zero-ext, 01 sign-ext, 10 sign-ext then shift left by 1, 11 reserved.
- out_valid  out  1  data_out holds a valid result.
- out_ready  in  1  consumer accepts the result.
- data_out  out  OUT_W  extended result.
- err  out  1  result produced from an illegal len or mode (qualified by out_valid).
- item_cnt  out  CNT_W  count of results accepted by the consumer.

Behaviour:
- Reset: when rst_n=0 at a rising edge, out_valid=0, data_out=0, err=0, item_cnt=0.
  - Reset overrides everything, including a pending result, which is dropped.
  - in_ready is combinational and not forced low by reset; it reads 1 right after reset.
- Handshake: in_ready = !out_valid || out_ready.
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Latency: exactly 1 cycle. An item accepted at edge N appears with out_valid=1 after edge N.
- Load rule: on accept, data_out, err and out_valid=1 are loaded.
- Clear rule: on output transfer without a simultaneous accept, out_valid goes to 0.
  - data_out and err hold their last values while out_valid=0.
- Simultaneous transfer and accept: the new item replaces the old one in the same edge, giving full throughput.
- Stall: while out_valid && !out_ready, data_out and err are held stable. in_valid is ignored because in_ready=0.
- Effective length L:
  - len if 1 <= len <= IN_W.
  - Otherwise L = IN_W and err = 1.
- Field extraction: f = data_in[L-1:0]. Bits data_in[IN_W-1:L] are ignored.
- Mode 00: data_out = f zero-extended to OUT_W.
- Mode 01: data_out[L-1:0] = f; data_out[OUT_W-1:L] = all copies of data_in[L-1].
- Mode 10: compute the mode-01 result, shift it left 1, truncate to OUT_W, so bit 0 = 0. Lost MSB is not flagged.
- Mode 11: handled as mode 00, with err = 1.
- err is the OR of the illegal-len and reserved-mode conditions.
- item_cnt: increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- X-safety: in_valid=0 means data_in, len and mode are don't-care; no register may load from them.

Test Plan (IN_W=10, OUT_W=16, LEN_W=4):
1. Basic modes, out_ready=1 throughout:
   - data_in=0x100, len=9, mode=01 -> data_out=0xFF00, err=0, one cycle after accept.
   - Same data_in with len=10 -> 0x0100.
   - Same with mode=00, len=9 -> 0x0100.
   - Same with mode=10, len=9 -> 0xFE00.
   - data_in=0x3FF, len=4, mode=01 -> 0xFFFF.
   - data_in=0x3F7, len=4, mode=01 -> 0x0007.
2. Illegal inputs:
   - len=0, data_in=0x200, mode=01 -> data_out=0xFE00, err=1.
   - len=12, data_in=0x0FF, mode=00 -> 0x00FF, err=1.
   - mode=11, data_in=0x3FF, len=10 -> 0x03FF, err=1.
3. Back-pressure:
   - Accept 0x005 (len=10, mode=01), then hold out_ready=0 for 3 cycles while in_valid=1 with 0x3FF.
   - Required: in_ready=0, data_out stays 0x0005, item_cnt unchanged.
   - Release out_ready: 0x0005 transfers and 0xFFFF loads on the same edge; item_cnt +1.
4. Streaming: 8 back-to-back items with in_valid=1 and out_ready=1 -> one result per cycle in order, no bubbles, item_cnt=8 at the end.
5. Reset mid-operation:
   - Put out_valid=1 under a stall, then apply rst_n=0 for one edge.
   - Required: out_valid=0, data_out=0, err=0, item_cnt=0 after that edge; in_ready=1; the next accepted item processes normally.
6. Counter wrap:
   - With CNT_W=4, perform 17 transfers -> item_cnt reads 15 after the 15th transfer, 0 after the 16th, 1 after the 17th.
